spi_txn_sequencer: RTL
======================

# spi_txn_sequencer

Transaction sequencer and round-robin arbiter sharing one `spi_master` between `N_REQ` requesters. Each requester submits a burst of 1..2^`LEN_W` bytes. The sequencer feeds the bytes one at a time through the `spi_master` write strobe and pacing status. It returns every received byte to the owning requester and signals completion or timeout. It sits directly above `spi_master`; the top level drives the `spi_master` reset from `~rst`.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `LEN_W`, 4, width of per-requester length field; burst bytes = `len`+1
- `TO_CYC`, 1024, watchdog limit in clk cycles per byte wait

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  N_REQ  level request per requester; held until `done`/`err`
- `req_len`  in  N_REQ*LEN_W  per-requester byte count minus one; sampled at grant
- `tx_data`  in  N_REQ*8  per-requester current tx byte
- `gnt`  out  N_REQ  one-hot owner, held for whole burst
- `tx_ack`  out  N_REQ  1-cycle pulse: current `tx_data` byte consumed; present the next byte
- `rx_data`  out  8  received byte
- `rx_valid`  out  N_REQ  1-cycle one-hot pulse qualifying `rx_data`
- `done`  out  N_REQ  1-cycle pulse: burst completed
- `err`  out  N_REQ  1-cycle pulse: burst aborted by watchdog
- `spi_apb_ready`  out  1  1-cycle write strobe to `spi_master`
- `spi_wdata`  out  8  byte to `spi_master`
- `spi_rdy`  in  1  `spi_master` ready (1) / busy (0) status
- `spi_rx_valid`  in  1  `spi_master` receive-byte pulse
- `spi_rdata`  in  8  `spi_master` received byte

## Operation
- States: IDLE, WAIT_RX, WAIT_RDY.
- **IDLE**
  - When `spi_rdy`=1 and any `req`, pick the winner round-robin, searching from `ptr`+1 mod `N_REQ`.
  - Set `ptr` to the winner and latch `req_len` into `len_q`. Clear `cnt` to 0.
  - Register `gnt`, `tx_ack`, `spi_apb_ready`=1 and `spi_wdata`=`tx_data[win]`.
  - Go to WAIT_RX.
- **WAIT_RX**
  - On `spi_rx_valid`: register `rx_data`=`spi_rdata` and pulse `rx_valid[g]`.
  - If `cnt`==`len_q`: pulse `done[g]`, clear `gnt`, go to IDLE.
  - Otherwise increment `cnt` and go to WAIT_RDY.
- **WAIT_RDY**
  - On `spi_rdy`=1: pulse `spi_apb_ready` and `tx_ack[g]`, with `spi_wdata`=`tx_data[g]`.
  - Go to WAIT_RX.
- **Watchdog**
  - `wd` counter is cleared on every entry to WAIT_RX or WAIT_RDY and increments each cycle while there.
  - When `wd`==`TO_CYC`-1: pulse `err[g]` (no `done`, no `rx_valid`), clear `gnt`, go to IDLE.
- **Request and length rules**
  - A `req` drop during a burst is ignored; the burst runs to completion.
  - Losing requesters wait; no preemption.
  - `cnt` and `len_q` are `LEN_W` bits; `len`=all-ones gives 2^`LEN_W` bytes with no wrap.
- **Reset values**
  - All outputs 0; state IDLE; `ptr`=`N_REQ`-1, so requester 0 wins first.
  - `cnt`, `len_q` and `wd` are 0.
  - Reset mid-burst abandons the burst immediately; no `done`/`err`.

## Timing
- All outputs registered.
- **Grant**: `req` and `spi_rdy` seen in IDLE at cycle t give `gnt`, `tx_ack`, `spi_apb_ready` and `spi_wdata` at t+1.
- **Byte receive**: `spi_rx_valid` at cycle u gives `rx_valid`/`rx_data` at u+1. On the last byte, `done` is also at u+1 and `gnt` goes low at u+1.
- **Next byte**: `spi_rdy` seen in WAIT_RDY at v gives the strobe at v+1. The minimum gap from `spi_rx_valid` to the next strobe is 2 cycles, even if `spi_rdy` is already high in the same cycle as `spi_rx_valid`.
- **Between bursts**: `gnt` is low for at least 1 cycle.
- **Requester tx handshake**: update `tx_data[i]` within 1 cycle of `tx_ack[i]`. It is next sampled no earlier than 3 cycles later.
- **spi_rdy low**: while `spi_rdy`=0 in IDLE, no grant is issued and `gnt` stays 0.

## Structure
- Package `spi_seq_pkg`:
  - state enum `seq_state_e`
  - default parameter constants
  - one-hot/index helper functions
- Sub-module `rr_arbiter` (params `N_REQ`):
  - combinational round-robin pick from `req` and `ptr`
  - outputs one-hot `win` and index `win_idx`
  - the sequencer owns the `ptr` register

## Test plan
- **Single burst**
  - Stimulus: `req`[0]=1, `req_len`[0]=2, bytes 0xA5, 0x3C, 0x0F; stub returns 0x11, 0x22, 0x33.
  - Required: exactly 3 `spi_apb_ready` pulses with those `spi_wdata` values; `rx_valid`[0] with 0x11, 0x22, 0x33; `done`[0] in the `rx_valid` cycle of 0x33.
- **Round-robin**
  - Stimulus: `req`=4'b1011 held, `req_len`=0 each.
  - Required: grant order 0, 1, 3, 0, 1, 3; never 2; `gnt` gap of at least 1 cycle each time.
- **Watchdog**
  - Stimulus: stub never pulses `spi_rx_valid`, `TO_CYC`=16.
  - Required: `err[g]` exactly 16 cycles after WAIT_RX entry; no `done`; back to IDLE.
- **Max length**
  - Stimulus: `req_len`=4'hF.
  - Required: 16 bytes transferred; `done` after the 16th; no early wrap.
- **Reset mid-burst and busy**
  - Stimulus: `rst` asserted after byte 1 of a 4-byte burst.
  - Required: next cycle all outputs 0; after release, requester 0 wins first.
  - Stimulus: `spi_rdy`=0 held in IDLE.
  - Required: no grant while `spi_rdy`=0.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared state enum, defaults and index helpers for the SPI transaction sequencer
package spi_seq_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_RX, WAIT_RDY} seq_state_e;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_TO_CYC = 1024;
  localparam int MAX_REQ = 8;
  function automatic int rr_idx(int p, int off, int n);
    return (p + off) % n;
  endfunction
  function automatic logic [MAX_REQ-1:0] idx2oh(int i);
    return MAX_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past ptr
module rr_arbiter import spi_seq_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [IW-1:0]    win_idx
);
  logic [IW-1:0] k;
  // scan farthest-first so the nearest requester after ptr overwrites the rest
  always_comb begin
    win_idx = '0;
    k = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = IW'(rr_idx(int'(ptr), i, N_REQ));
      if (req[k]) win_idx = k;
    end
  end
  assign win = |req ? N_REQ'(idx2oh(int'(win_idx))) : '0;
endmodule

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: round-robin burst sequencer sharing one spi_master among N_REQ requesters
module spi_txn_sequencer import spi_seq_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int LEN_W = DEF_LEN_W,
  parameter int TO_CYC = DEF_TO_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic [N_REQ*8-1:0]     tx_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       tx_ack,
  output logic [7:0]             rx_data,
  output logic [N_REQ-1:0]       rx_valid,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic                   spi_apb_ready,
  output logic [7:0]             spi_wdata,
  input  logic                   spi_rdy,
  input  logic                   spi_rx_valid,
  input  logic [7:0]             spi_rdata
);
  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TO_CYC);
  seq_state_e state, nxt;
  logic [IW-1:0] ptr, g_idx, win_idx;
  logic [N_REQ-1:0] win;
  logic [LEN_W-1:0] len_q, cnt;
  logic [WW-1:0] wd;
  logic wd_to, last;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req),
    .ptr(ptr),
    .win(win),
    .win_idx(win_idx)
  );
  assign wd_to = wd == WW'(TO_CYC - 1);
  assign last = cnt == len_q;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // a received byte wins over a coincident watchdog expiry
  always_comb
    nxt = state == IDLE ? ((spi_rdy && |req) ? WAIT_RX : IDLE)
        : state == WAIT_RX ? (spi_rx_valid ? (last ? IDLE : WAIT_RDY) : (wd_to ? IDLE : WAIT_RX))
        : (spi_rdy ? WAIT_RX : (wd_to ? IDLE : WAIT_RDY));
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt <= '0;
      tx_ack <= '0;
      rx_data <= '0;
      rx_valid <= '0;
      done <= '0;
      err <= '0;
      spi_apb_ready <= 1'b0;
      spi_wdata <= '0;
      ptr <= IW'(N_REQ - 1);
      g_idx <= '0;
      len_q <= '0;
      cnt <= '0;
      wd <= '0;
    end else begin
      tx_ack <= '0;
      rx_valid <= '0;
      done <= '0;
      err <= '0;
      spi_apb_ready <= 1'b0;
      wd <= (state != IDLE && nxt == state) ? wd + 1'b1 : '0;
      case (state)
        IDLE: if (spi_rdy && |req) begin
          ptr <= win_idx;
          g_idx <= win_idx;
          len_q <= req_len[win_idx*LEN_W +: LEN_W];
          cnt <= '0;
          gnt <= win;
          tx_ack <= win;
          spi_apb_ready <= 1'b1;
          spi_wdata <= tx_data[{win_idx, 3'b000} +: 8];
        end
        WAIT_RX: if (spi_rx_valid) begin
          rx_data <= spi_rdata;
          rx_valid <= gnt;
          if (last) begin
            done <= gnt;
            gnt <= '0;
          end else cnt <= cnt + 1'b1;
        end else if (wd_to) begin
          err <= gnt;
          gnt <= '0;
        end
        WAIT_RDY: if (spi_rdy) begin
          spi_apb_ready <= 1'b1;
          tx_ack <= gnt;
          spi_wdata <= tx_data[{g_idx, 3'b000} +: 8];
        end else if (wd_to) begin
          err <= gnt;
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
